// File: rtl/count_event_monitor_if.sv
// Event record port of count_event_monitor: valid/ready handshake plus record fields.
// The monitor drives the master side; the checker/scoreboard consumes on the slave side.
interface count_event_monitor_if #(
   parameter int EPOCH_W = 8,
   parameter int TS_W    = 16
);
   logic               evt_valid;
   logic               evt_ready;
   logic [1:0]         evt_kind;
   logic [EPOCH_W-1:0] evt_epoch;
   logic [TS_W-1:0]    evt_ts;

   modport master (output evt_valid, evt_kind, evt_epoch, evt_ts, input evt_ready);
   modport slave  (input evt_valid, evt_kind, evt_epoch, evt_ts, output evt_ready);
endinterface

// File: rtl/count_event_monitor.sv
// Watches the Counter stage's count, classifies each sampled transition and queues
// timestamped WRAP/CRESET/SKIP/STALL records in a small FIFO.
module count_event_monitor #(
   parameter int CNT_W       = 4,
   parameter int EPOCH_W     = 8,
   parameter int TS_W        = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int STALL_LIMIT = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CNT_W-1:0]               cnt_in_i,
   input  logic                           cnt_en_i,
   input  logic                           clr_overflow_i,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
   output logic                           stalled_o,
   output logic                           overflow_o,
   count_event_monitor_if.master          evt_if
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STALL_LIMIT + 1);
   localparam int REC_W = 2 + EPOCH_W + TS_W;

   typedef enum logic [1:0] {
      KIND_WRAP   = 2'b00,
      KIND_CRESET = 2'b01,
      KIND_SKIP   = 2'b10,
      KIND_STALL  = 2'b11
   } evt_kind_e;

   logic [TS_W-1:0]    ts_q;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic [CNT_W-1:0]   prev_q, prev_d, nxt_s;
   logic               primed_q, primed_d;
   logic [SC_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic               stalled_q, stalled_d;
   logic               overflow_q, overflow_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               valid_q;
   logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
   logic               push_s, pop_s, full_s, accept_s, drop_s;
   evt_kind_e          kind_s;

   // Transition classifier: decides the event and the next baseline/epoch/stall state
   always_comb begin
      epoch_d     = epoch_q;
      prev_d      = prev_q;
      primed_d    = primed_q;
      stall_cnt_d = stall_cnt_q;
      stalled_d   = stalled_q;
      push_s      = 1'b0;
      kind_s      = KIND_WRAP;
      nxt_s       = prev_q + CNT_W'(1);
      if (cnt_en_i) begin
         if (!primed_q) begin
            primed_d = 1'b1;
            prev_d   = cnt_in_i;
         end else if (cnt_in_i == prev_q) begin
            // Saturating count guarantees a single STALL per unchanged episode
            if (stall_cnt_q < SC_W'(STALL_LIMIT)) begin
               stall_cnt_d = stall_cnt_q + SC_W'(1);
               if (stall_cnt_q == SC_W'(STALL_LIMIT - 1)) begin
                  push_s    = 1'b1;
                  kind_s    = KIND_STALL;
                  stalled_d = 1'b1;
               end else begin
                  push_s = 1'b0;
               end
            end else begin
               stall_cnt_d = stall_cnt_q;
            end
         end else begin
            stall_cnt_d = '0;
            stalled_d   = 1'b0;
            prev_d      = cnt_in_i;
            if (cnt_in_i == nxt_s) begin
               if (prev_q == {CNT_W{1'b1}}) begin
                  epoch_d = epoch_q + EPOCH_W'(1);
                  push_s  = 1'b1;
                  kind_s  = KIND_WRAP;
               end else begin
                  push_s = 1'b0;
               end
            end else if (cnt_in_i == '0) begin
               epoch_d = '0;
               push_s  = 1'b1;
               kind_s  = KIND_CRESET;
            end else begin
               push_s = 1'b1;
               kind_s = KIND_SKIP;
            end
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // FIFO control: a push into a full FIFO survives only if the head pops the same cycle
   always_comb begin
      full_s   = (level_q == LVL_W'(FIFO_DEPTH));
      pop_s    = valid_q && evt_if.evt_ready;
      accept_s = push_s && (!full_s || pop_s);
      drop_s   = push_s && full_s && !pop_s;
      level_d  = level_q + LVL_W'(accept_s) - LVL_W'(pop_s);
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (clr_overflow_i) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // State and FIFO storage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q        <= '0;
         epoch_q     <= '0;
         prev_q      <= '0;
         primed_q    <= 1'b0;
         stall_cnt_q <= '0;
         stalled_q   <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         valid_q     <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ts_q        <= ts_q + TS_W'(1);
         epoch_q     <= epoch_d;
         prev_q      <= prev_d;
         primed_q    <= primed_d;
         stall_cnt_q <= stall_cnt_d;
         stalled_q   <= stalled_d;
         overflow_q  <= overflow_d;
         level_q     <= level_d;
         valid_q     <= (level_d != '0);
         if (accept_s) begin
            mem_q[wr_ptr_q] <= {kind_s, epoch_d, ts_q};
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   assign evt_if.evt_valid = valid_q;
   assign evt_if.evt_kind  = mem_q[rd_ptr_q][REC_W-1 -: 2];
   assign evt_if.evt_epoch = mem_q[rd_ptr_q][TS_W +: EPOCH_W];
   assign evt_if.evt_ts    = mem_q[rd_ptr_q][TS_W-1:0];
   assign fifo_level_o     = level_q;
   assign stalled_o        = stalled_q;
   assign overflow_o       = overflow_q;
endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: hand-computed event kinds, epochs and
// timestamps checked with immediate assertions.
module tb_count_event_monitor;
   localparam logic [1:0] K_WRAP   = 2'b00;
   localparam logic [1:0] K_CRESET = 2'b01;
   localparam logic [1:0] K_SKIP   = 2'b10;
   localparam logic [1:0] K_STALL  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cnt_in;
   logic        cnt_en;
   logic        clr_overflow;
   logic [2:0]  fifo_level;
   logic        stalled;
   logic        overflow;
   logic [15:0] cyc = 16'd0;
   logic [15:0] last_ts;
   logic [15:0] t [8];
   int          n_total = 0;
   int          n_pass  = 0;

   count_event_monitor_if #(.EPOCH_W(8), .TS_W(16)) evt_if ();

   count_event_monitor dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cnt_in_i       (cnt_in),
      .cnt_en_i       (cnt_en),
      .clr_overflow_i (clr_overflow),
      .fifo_level_o   (fifo_level),
      .stalled_o      (stalled),
      .overflow_o     (overflow),
      .evt_if         (evt_if)
   );

   always #5 clk = ~clk;

   // Reference time base: cycles elapsed since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 16'd0;
      else        cyc <= cyc + 16'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [3:0] v);
      cnt_en  = 1'b1;
      cnt_in  = v;
      last_ts = cyc;
      step();
      cnt_en  = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [1:0] k,
                            input logic [7:0] ep, input logic [15:0] ts);
      chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd1);
      chk({tag, "_kind"},  32'(evt_if.evt_kind),  32'(k));
      chk({tag, "_epoch"}, 32'(evt_if.evt_epoch), 32'(ep));
      chk({tag, "_ts"},    32'(evt_if.evt_ts),    32'(ts));
      evt_if.evt_ready = 1'b1;
      step();
      evt_if.evt_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cnt_in = 4'd0; cnt_en = 1'b0; clr_overflow = 1'b0;
      evt_if.evt_ready = 1'b0;
      #12;
      chk("rst_valid",    32'(evt_if.evt_valid), 32'd0);
      chk("rst_level",    32'(fifo_level),       32'd0);
      chk("rst_stalled",  32'(stalled),          32'd0);
      chk("rst_overflow", 32'(overflow),         32'd0);
      chk("rst_kind",     32'(evt_if.evt_kind),  32'd0);
      step();
      rst_n = 1'b1;

      // 1: full count cycle, one WRAP
      for (int v = 0; v < 16; v++) sample(4'(v));
      chk("t1_no_evt", 32'(fifo_level), 32'd0);
      sample(4'd0);
      t[0] = last_ts;
      chk("t1_latency", 32'(evt_if.evt_valid), 32'd1);
      sample(4'd1);
      chk("t1_level", 32'(fifo_level), 32'd1);
      pop_check("t1_wrap", K_WRAP, 8'd1, t[0]);
      chk("t1_drained", 32'(fifo_level), 32'd0);

      // 2: SKIPs keep epoch, CRESET zeroes it
      sample(4'd3); t[0] = last_ts;
      sample(4'd9); t[1] = last_ts;
      sample(4'd5); t[2] = last_ts;
      sample(4'd6);
      sample(4'd0); t[3] = last_ts;
      chk("t2_level", 32'(fifo_level), 32'd4);
      pop_check("t2_skip0", K_SKIP,   8'd1, t[0]);
      pop_check("t2_skip1", K_SKIP,   8'd1, t[1]);
      pop_check("t2_skip2", K_SKIP,   8'd1, t[2]);
      pop_check("t2_creset", K_CRESET, 8'd0, t[3]);

      // 3: hold at 7, disabled cycles in the middle are not counted
      sample(4'd7); t[0] = last_ts;
      pop_check("t3_skip", K_SKIP, 8'd0, t[0]);
      for (int i = 0; i < 4; i++) sample(4'd7);
      cnt_in = 4'd2;
      repeat (3) step();
      for (int i = 0; i < 3; i++) sample(4'd7);
      chk("t3_pre_stalled", 32'(stalled),    32'd0);
      chk("t3_pre_level",   32'(fifo_level), 32'd0);
      sample(4'd7); t[1] = last_ts;
      chk("t3_stalled", 32'(stalled),    32'd1);
      chk("t3_level",   32'(fifo_level), 32'd1);
      for (int i = 0; i < 4; i++) sample(4'd7);
      chk("t3_single",     32'(fifo_level), 32'd1);
      chk("t3_still_stal", 32'(stalled),    32'd1);
      sample(4'd8);
      chk("t3_unstalled", 32'(stalled), 32'd0);
      pop_check("t3_stall", K_STALL, 8'd0, t[1]);

      // 4: overflow on full FIFO, set beats clear
      sample(4'd10); t[0] = last_ts;
      sample(4'd12); t[1] = last_ts;
      sample(4'd14); t[2] = last_ts;
      sample(4'd1);  t[3] = last_ts;
      chk("t4_full",   32'(fifo_level), 32'd4);
      chk("t4_no_ovf", 32'(overflow),   32'd0);
      sample(4'd3);
      chk("t4_drop_level", 32'(fifo_level), 32'd4);
      chk("t4_ovf",        32'(overflow),   32'd1);
      clr_overflow = 1'b1;
      sample(4'd5);
      clr_overflow = 1'b0;
      chk("t4_set_wins", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      chk("t4_cleared", 32'(overflow), 32'd0);

      // 5: push with simultaneous pop on a full FIFO
      chk("t5_head", 32'(evt_if.evt_ts), 32'(t[0]));
      evt_if.evt_ready = 1'b1;
      sample(4'd7); t[4] = last_ts;
      evt_if.evt_ready = 1'b0;
      chk("t5_level", 32'(fifo_level), 32'd4);
      chk("t5_ovf",   32'(overflow),   32'd0);
      pop_check("t5_e1", K_SKIP, 8'd0, t[1]);
      pop_check("t5_e2", K_SKIP, 8'd0, t[2]);
      pop_check("t5_e3", K_SKIP, 8'd0, t[3]);
      pop_check("t5_e4", K_SKIP, 8'd0, t[4]);
      chk("t5_empty", 32'(fifo_level), 32'd0);

      // 6: asynchronous reset with queued events, then re-baseline
      sample(4'd9);
      sample(4'd11);
      sample(4'd13);
      chk("t6_level", 32'(fifo_level), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(evt_if.evt_valid), 32'd0);
      chk("t6_rst_level", 32'(fifo_level),       32'd0);
      step();
      rst_n = 1'b1;
      sample(4'd4);
      chk("t6_baseline", 32'(evt_if.evt_valid), 32'd0);
      sample(4'd5);
      chk("t6_step", 32'(fifo_level), 32'd0);
      sample(4'd0); t[0] = last_ts;
      chk("t6_level1", 32'(fifo_level), 32'd1);
      pop_check("t6_creset", K_CRESET, 8'd0, t[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
